// File: rtl/seg_scan_driver_pkg.sv
// Shared types and glyph table for the multiplexed seven-segment driver.
// Segment bit order: bit0 = a ... bit6 = g, active-high.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = '0;

    // Hex glyphs 0..F; b and d use the lowercase shapes.
    localparam seg_t SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Glyph for one nibble, or blank when the digit is suppressed.
    function automatic seg_t seg_glyph(input logic [3:0] nib,
                                       input logic       blank);
        seg_glyph = blank ? SEG_BLANK : SEG_HEX[nib];
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Value-load and display-pin bundle of the seven-segment scan driver.
// master = value source / board side, slave = the driver itself.
interface seg_scan_driver_if
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 3
) ();

    localparam int SEL_W = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] value_i;
    logic                    load_i;
    logic [BRIGHT_W-1:0]     brightness_i;
    logic                    pending_o;
    logic [SEL_W-1:0]        digit_sel_o;
    logic [NUM_DIGITS-1:0]   digit_en_o;
    seg_t                    segs_o;
    logic                    frame_o;

    modport master (
        output value_i,
        output load_i,
        output brightness_i,
        input  pending_o,
        input  digit_sel_o,
        input  digit_en_o,
        input  segs_o,
        input  frame_o
    );

    modport slave (
        input  value_i,
        input  load_i,
        input  brightness_i,
        output pending_o,
        output digit_sel_o,
        output digit_en_o,
        output segs_o,
        output frame_o
    );

endinterface

// File: rtl/seg_scan_timer.sv
// Slot prescaler, digit scan counter, frame boundary and PWM duty compare.
// Exposes next-state scan/duty so the top can register outputs alongside.
module seg_scan_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 10000,
    parameter int BRIGHT_W   = 3,
    localparam int SEL_W     = $clog2(NUM_DIGITS)
) (
    input  logic                clk_i,
    input  logic                reset,
    input  logic [BRIGHT_W-1:0] brightness_i,
    output logic [SEL_W-1:0]    scan_nxt_o,
    output logic                en_nxt_o,
    output logic                boundary_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int P_W   = CNT_W + BRIGHT_W + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [SEL_W-1:0] scan_q;
    logic [SEL_W-1:0] scan_nxt;
    logic             tick;
    logic             last;
    logic [P_W-1:0]   lvl;
    logic [P_W-1:0]   prod;
    logic [P_W-1:0]   th;

    assign tick = (cnt_q == CNT_W'(DIV - 1));
    assign last = (scan_q == SEL_W'(NUM_DIGITS - 1));

    // Next prescaler and scan positions; scan only moves at slot end.
    always_comb begin
        cnt_nxt  = cnt_q + 1'b1;
        scan_nxt = scan_q;
        if (tick) begin
            cnt_nxt  = '0;
            scan_nxt = last ? '0 : scan_q + 1'b1;
        end
    end

    // On-time per slot: ((level + 1) * DIV) >> BRIGHT_W, full-width product.
    always_comb begin
        lvl  = P_W'(brightness_i) + P_W'(1);
        prod = lvl * P_W'(DIV);
        th   = prod >> BRIGHT_W;
    end

    // Prescaler and scan index state.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            cnt_q  <= '0;
            scan_q <= '0;
        end else begin
            cnt_q  <= cnt_nxt;
            scan_q <= scan_nxt;
        end
    end

    assign scan_nxt_o = scan_nxt;
    assign en_nxt_o   = (P_W'(cnt_nxt) < th);
    assign boundary_o = tick & last;

endmodule

// File: rtl/seg_scan_driver.sv
// N-digit multiplexed seven-segment driver with double-buffered load and PWM.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 10000,
    parameter int BRIGHT_W   = 3
) (
    input  logic              clk_i,
    input  logic              reset,
    seg_scan_driver_if.slave  bus
);

    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = 4 * NUM_DIGITS;

    logic [SEL_W-1:0]      scan_nxt;
    logic                  en_nxt;
    logic                  boundary;

    logic [VAL_W-1:0]      pend_q;
    logic [VAL_W-1:0]      pend_nxt;
    logic [VAL_W-1:0]      disp_q;
    logic [VAL_W-1:0]      disp_nxt;
    logic                  pending_q;
    logic                  pending_nxt;

    logic [NUM_DIGITS-1:0] blank;
    logic [3:0]            nib;
    logic                  blank_cur;

    logic [SEL_W-1:0]      sel_q;
    logic [NUM_DIGITS-1:0] en_q;
    seg_t                  segs_q;
    logic                  frame_q;

    seg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .DIV          (DIV),
        .BRIGHT_W     (BRIGHT_W)
    ) u_timer (
        .clk_i        (clk_i),
        .reset        (reset),
        .brightness_i (bus.brightness_i),
        .scan_nxt_o   (scan_nxt),
        .en_nxt_o     (en_nxt),
        .boundary_o   (boundary)
    );

    // Commit pending data at the frame boundary; a load always lands in pend.
    always_comb begin
        disp_nxt    = disp_q;
        pend_nxt    = pend_q;
        pending_nxt = pending_q;
        if (boundary && pending_q) begin
            disp_nxt    = pend_q;
            pending_nxt = 1'b0;
        end
        if (bus.load_i) begin
            pend_nxt    = bus.value_i;
            pending_nxt = 1'b1;
        end
    end

`ifdef SEG_LZB_EN
    // Digit i>=1 is blank when it and every higher nibble are zero.
    always_comb begin
        logic run;
        run   = 1'b1;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run      = run & (disp_nxt[4*i +: 4] == 4'h0);
            blank[i] = run;
        end
    end
`else
    assign blank = '0;
`endif

    assign nib       = disp_nxt[{scan_nxt, 2'b00} +: 4];
    assign blank_cur = blank[scan_nxt];

    // Buffers and pins, registered from the state being entered this edge.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            pend_q    <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            sel_q     <= '0;
            en_q      <= '0;
            segs_q    <= SEG_BLANK;
            frame_q   <= 1'b0;
        end else begin
            pend_q    <= pend_nxt;
            disp_q    <= disp_nxt;
            pending_q <= pending_nxt;
            sel_q     <= scan_nxt;
            en_q      <= (en_nxt && !blank_cur)
                         ? (NUM_DIGITS'(1) << scan_nxt)
                         : '0;
            segs_q    <= seg_glyph(nib, blank_cur);
            frame_q   <= boundary;
        end
    end

    assign bus.pending_o   = pending_q;
    assign bus.digit_sel_o = sel_q;
    assign bus.digit_en_o  = en_q;
    assign bus.segs_o      = segs_q;
    assign bus.frame_o     = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random loads/brightness,
// every cycle compared against a time-indexed behavioural model.
module tb_seg_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int BW  = 3;
    localparam int FR  = N * DIV;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seg_scan_driver_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) bus ();

    seg_scan_driver #(
        .NUM_DIGITS (N),
        .DIV        (DIV),
        .BRIGHT_W   (BW)
    ) dut (
        .clk_i      (clk),
        .reset      (reset),
        .bus        (bus.slave)
    );

    logic [6:0] hex_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int checks = 0;
    int errors = 0;

    // Model: mt = cycles elapsed since reset; slot/digit follow by division.
    int          mt;
    logic [15:0] mdisp;
    logic [15:0] mpend;
    bit          mpending;
    logic [31:0] e_sel, e_en, e_segs, e_frame, e_pend;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_blank(input logic [15:0] d, input int i);
`ifdef SEG_LZB_EN
        if (i == 0) return 1'b0;
        return (d >> (4 * i)) == 16'h0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic cyc();
        bit bnd;
        bit bl;
        int c, s, th;
        @(posedge clk);
        if (reset) begin
            mt = 0; mdisp = '0; mpend = '0; mpending = 0;
            e_sel = 0; e_en = 0; e_segs = 0; e_frame = 0; e_pend = 0;
        end else begin
            bnd = (mt % FR) == FR - 1;
            if (bnd && mpending) begin
                mdisp    = mpend;
                mpending = 0;
            end
            if (bus.load_i) begin
                mpend    = bus.value_i;
                mpending = 1;
            end
            mt++;
            c  = mt % DIV;
            s  = (mt / DIV) % N;
            th = ((int'(bus.brightness_i) + 1) * DIV) >> BW;
            bl = is_blank(mdisp, s);
            e_sel   = s;
            e_en    = (!bl && c < th) ? (32'd1 << s) : 32'd0;
            e_segs  = bl ? 32'd0 : 32'(hex_tab[(mdisp >> (4 * s)) & 16'hF]);
            e_frame = 32'(bnd);
            e_pend  = 32'(mpending);
        end
        @(negedge clk);
        chk("digit_sel", 32'(bus.digit_sel_o), e_sel);
        chk("digit_en",  32'(bus.digit_en_o),  e_en);
        chk("segs",      32'(bus.segs_o),      e_segs);
        chk("frame",     32'(bus.frame_o),     e_frame);
        chk("pending",   32'(bus.pending_o),   e_pend);
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.value_i = v;
        bus.load_i  = 1'b1;
        cyc();
        bus.load_i  = 1'b0;
    endtask

    task automatic wait_frame(input int maxc);
        int k = 0;
        while (bus.frame_o !== 1'b1 && k < maxc) begin
            cyc();
            k++;
        end
        chk("frame_seen", 32'(bus.frame_o), 32'd1);
    endtask

    logic [6:0] got_seg [N];
    bit         got_en  [N];

    task automatic grab_frame();
        for (int s = 0; s < N; s++) begin
            got_seg[s] = bus.segs_o;
            got_en[s]  = bus.digit_en_o != '0;
            repeat (DIV) cyc();
        end
    endtask

    initial begin
        int k;
        int lit;
        int blist [3] = '{0, 3, 7};
        reset            = 1'b1;
        bus.value_i      = '0;
        bus.load_i       = 1'b0;
        bus.brightness_i = 3'd7;

        repeat (3) cyc();
        chk("rst_sel",  32'(bus.digit_sel_o), 32'd0);
        chk("rst_en",   32'(bus.digit_en_o),  32'd0);
        chk("rst_segs", 32'(bus.segs_o),      32'd0);
        chk("rst_pend", 32'(bus.pending_o),   32'd0);
        reset = 1'b0;

        k = 0;
        while (bus.digit_sel_o !== 2'd1 && k < 20) begin
            cyc();
            k++;
        end
        chk("first_step", k, 8);

        do_load(16'h12AF);
        chk("pend_12af", 32'(bus.pending_o), 32'd1);
        wait_frame(FR + 2);
        chk("f_sel", 32'(bus.digit_sel_o), 32'd0);
        chk("f_segs", 32'(bus.segs_o), 32'h71);
        chk("f_en", 32'(bus.digit_en_o), 32'd1);
        chk("f_pend", 32'(bus.pending_o), 32'd0);

        repeat (3) cyc();
        do_load(16'h1111);
        repeat (5) cyc();
        do_load(16'h2222);
        k = 0;
        while ((mt % FR) != FR - 1 && k < FR) begin
            cyc();
            k++;
        end
        do_load(16'h3333);
        chk("b_frame", 32'(bus.frame_o), 32'd1);
        chk("b_segs", 32'(bus.segs_o), 32'h5B);
        chk("b_pend", 32'(bus.pending_o), 32'd1);
        cyc();
        wait_frame(FR + 2);
        chk("n_segs", 32'(bus.segs_o), 32'h4F);
        chk("n_pend", 32'(bus.pending_o), 32'd0);

        for (int i = 0; i < 3; i++) begin
            bus.brightness_i = 3'(blist[i]);
            lit = 0;
            repeat (FR) begin
                cyc();
                if (bus.digit_en_o != '0) lit++;
            end
            chk($sformatf("lit_b%0d", blist[i]), lit, N * (blist[i] + 1));
        end
        bus.brightness_i = 3'd7;

        do_load(16'h0050);
        wait_frame(FR + 2);
        grab_frame();
        chk("z_d0", 32'(got_seg[0]), 32'h3F);
        chk("z_d1", 32'(got_seg[1]), 32'h6D);
`ifdef SEG_LZB_EN
        chk("z_d2", 32'(got_seg[2]), 32'h00);
        chk("z_d3", 32'(got_seg[3]), 32'h00);
        chk("z_e2", 32'(got_en[2]), 32'd0);
        chk("z_e3", 32'(got_en[3]), 32'd0);
`else
        chk("z_d2", 32'(got_seg[2]), 32'h3F);
        chk("z_d3", 32'(got_seg[3]), 32'h3F);
        chk("z_e2", 32'(got_en[2]), 32'd1);
        chk("z_e3", 32'(got_en[3]), 32'd1);
`endif
        do_load(16'h0000);
        wait_frame(FR + 2);
        grab_frame();
        chk("zz_e0", 32'(got_en[0]), 32'd1);
`ifdef SEG_LZB_EN
        chk("zz_e1", 32'(got_en[1]), 32'd0);
        chk("zz_s3", 32'(got_seg[3]), 32'h00);
`else
        chk("zz_e1", 32'(got_en[1]), 32'd1);
        chk("zz_s3", 32'(got_seg[3]), 32'h3F);
`endif

        do_load(16'h8888);
        wait_frame(FR + 2);
        repeat (5) cyc();
        do_load(16'hABCD);
        reset = 1'b1;
        repeat (2) cyc();
        chk("r_pend", 32'(bus.pending_o), 32'd0);
        reset = 1'b0;
        cyc();
        chk("r_pend2", 32'(bus.pending_o), 32'd0);
        chk("r_segs", 32'(bus.segs_o), 32'h3F);
        wait_frame(FR + 2);
        chk("r_disp", 32'(bus.segs_o), 32'h3F);

        for (int i = 0; i < 800; i++) begin
            bus.value_i      = 16'($urandom);
            bus.load_i       = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0)
                bus.brightness_i = 3'($urandom_range(0, 7));
            cyc();
        end
        bus.load_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
